// File: rtl/ysyx_040066_pc_ctrl_if.sv
// Fetch-side bundle: EX redirect, imem request/response and ID delivery.
// master = PC sequencer, slave = its environment (EX, imem, ID).
interface ysyx_040066_pc_ctrl_if;
    logic        stall;
    logic        ex_redir;
    logic [63:0] ex_redir_pc;

    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_pc;

    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;

    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        input  stall, ex_redir, ex_redir_pc,
        output if_req_valid, if_req_pc,
        input  if_req_ready,
        input  if_rsp_valid, if_rsp_inst,
        output id_valid, id_pc, id_inst,
        input  id_ready
    );

    modport slave (
        output stall, ex_redir, ex_redir_pc,
        input  if_req_valid, if_req_pc,
        output if_req_ready,
        output if_rsp_valid, if_rsp_inst,
        input  id_valid, id_pc, id_inst,
        output id_ready
    );
endinterface

// File: rtl/ysyx_040066_pc_ctrl.sv
// Fetch PC sequencer: issues in-order imem requests under a MAX_OUT credit, buffers responses for ID
// (response edge N -> id_valid cycle N+1); ID backpressure holds the FIFO and throttles new requests.
module ysyx_040066_pc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          MAX_OUT  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_040066_pc_ctrl_if.master  bus
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW:0] MAX_W = (CW + 1)'(MAX_OUT);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {RUN, DRAIN} state_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MAX_OUT - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        discard_q, discard_d;
    cnt_t        count_q, count_d;
    ptr_t        wr_ptr_q, rd_ptr_q;
    ptr_t        tag_wr_q, tag_rd_q;

    logic [63:0] fifo_pc   [MAX_OUT];
    logic [31:0] fifo_inst [MAX_OUT];
    logic [63:0] tag_pc    [MAX_OUT];

    logic [CW:0] used;
    logic        req_vld, fire, rsp_acc, drop, push, id_vld, pop;

    always_comb begin
        used    = {1'b0, inflight_q} + {1'b0, count_q};
        // Credit covers both in-flight and buffered slots, so a push can never find the FIFO full.
        req_vld = rst_n && !bus.stall && !bus.ex_redir && (used < MAX_W);
        fire    = req_vld && bus.if_req_ready;
        rsp_acc = bus.if_rsp_valid && (inflight_q != '0);
        drop    = rsp_acc && (bus.ex_redir || state_q == DRAIN);
        push    = rsp_acc && !drop;
        id_vld  = (count_q != '0) && !bus.ex_redir;
        pop     = id_vld && bus.id_ready;
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        state_d    = state_q;

        if (fire && !rsp_acc)
            inflight_d = inflight_q + cnt_t'(1);
        else if (!fire && rsp_acc)
            inflight_d = inflight_q - cnt_t'(1);

        if (bus.ex_redir) begin
            // Everything still owed belongs to the old path, including anything already draining.
            pc_d      = bus.ex_redir_pc;
            discard_d = inflight_q - cnt_t'(rsp_acc);
            count_d   = '0;
        end else begin
            if (fire)
                pc_d = pc_q + 64'd4;
            if (rsp_acc && discard_q != '0)
                discard_d = discard_q - cnt_t'(1);
            if (push && !pop)
                count_d = count_q + cnt_t'(1);
            else if (!push && pop)
                count_d = count_q - cnt_t'(1);
        end

        state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            if (fire)
                tag_wr_q <= ptr_inc(tag_wr_q);
            if (rsp_acc)
                tag_rd_q <= ptr_inc(tag_rd_q);
            if (bus.ex_redir) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            tag_pc[tag_wr_q] <= pc_q;
        if (push) begin
            fifo_pc[wr_ptr_q]   <= tag_pc[tag_rd_q];
            fifo_inst[wr_ptr_q] <= bus.if_rsp_inst;
        end
    end

    assign bus.if_req_valid = req_vld;
    assign bus.if_req_pc    = pc_q;
    assign bus.id_valid     = id_vld;
    assign bus.id_pc        = (count_q != '0) ? fifo_pc[rd_ptr_q]   : 64'd0;
    assign bus.id_inst      = (count_q != '0) ? fifo_inst[rd_ptr_q] : 32'd0;
endmodule
